// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the FND segment receiver path.
//   - Active-low segment codes {a,b,c,d,e,f,g} for hex digits 0..F.
//   - SEG_BLANK: all segments off.
//   - State encoding for the fnd_rx settle FSM.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0D;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/fnd_seg2hex.sv
// fnd_seg2hex: combinational inverse of the hex-to-segment decoder.
// Ports:
//   seg_i      [6:0]  active-low segment pattern {a,b,c,d,e,f,g}
//   value_o    [3:0]  recovered hex value (0 when not a legal digit)
//   legal_o           pattern is one of the sixteen digit codes
//   is_blank_o        pattern is all segments off
module fnd_seg2hex
    import fnd_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       legal_o,
    output logic       is_blank_o
);

    always_comb begin
        value_o    = '0;
        legal_o    = 1'b1;
        is_blank_o = 1'b0;
        case (seg_i)
            SEG_0:     value_o = 4'h0;
            SEG_1:     value_o = 4'h1;
            SEG_2:     value_o = 4'h2;
            SEG_3:     value_o = 4'h3;
            SEG_4:     value_o = 4'h4;
            SEG_5:     value_o = 4'h5;
            SEG_6:     value_o = 4'h6;
            SEG_7:     value_o = 4'h7;
            SEG_8:     value_o = 4'h8;
            SEG_9:     value_o = 4'h9;
            SEG_A:     value_o = 4'hA;
            SEG_B:     value_o = 4'hB;
            SEG_C:     value_o = 4'hC;
            SEG_D:     value_o = 4'hD;
            SEG_E:     value_o = 4'hE;
            SEG_F:     value_o = 4'hF;
            SEG_BLANK: begin
                legal_o    = 1'b0;
                is_blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_rx.sv
// fnd_rx: seven-segment pattern receiver. Samples an active-low segment bus,
// waits for the pattern to hold for STABLE_CYCLES qualified samples, then
// reports the hex value (valid pulse), a blank, or an illegal code (code_err
// pulse). A held pattern is accepted only once.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   seg_in    [6:0]   segment bus {a,b,c,d,e,f,g}, 0 = lit
//   sample_en         sample qualifier; low freezes sampling and settling
//   clr_cnt           synchronous clear of err_cnt (clear beats increment)
//   number    [3:0]   last accepted hex value
//   blank             last accepted pattern was blank
//   valid             1-cycle pulse on legal digit / blank acceptance
//   code_err          1-cycle pulse on illegal pattern acceptance
//   err_cnt   [CNT_W-1:0] saturating illegal-acceptance count
// Build option: FND_RX_ERRCNT_EN enables err_cnt/clr_cnt; when undefined
// err_cnt reads 0 and clr_cnt is ignored.
module fnd_rx
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             sample_en,
    input  logic             clr_cnt,
    output logic [3:0]       number,
    output logic             blank,
    output logic             valid,
    output logic             code_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    state_e          state_q;
    logic [6:0]      seg_q;
    logic [6:0]      cand_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      number_q;
    logic            blank_q;
    logic            valid_q;
    logic            code_err_q;

    logic [3:0]      cand_value;
    logic            cand_legal;
    logic            cand_blank;
    logic            accept;

    fnd_seg2hex u_seg2hex (
        .seg_i      (cand_q),
        .value_o    (cand_value),
        .legal_o    (cand_legal),
        .is_blank_o (cand_blank)
    );

    // Final settle step: cand already equals seg_q, so decoding cand is safe.
    always_comb begin
        accept = sample_en && (state_q == ST_SETTLE) && (seg_q == cand_q) &&
                 (cnt_q == CW'(STABLE_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seg_q      <= SEG_BLANK;
            cand_q     <= SEG_BLANK;
            cnt_q      <= '0;
            number_q   <= '0;
            blank_q    <= 1'b1;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            if (sample_en) begin
                seg_q <= seg_in;
                case (state_q)
                    ST_IDLE: begin
                        cand_q  <= seg_q;
                        cnt_q   <= CW'(1);
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (seg_q != cand_q) begin
                            cand_q <= seg_q;
                            cnt_q  <= CW'(1);
                        end else if (accept) begin
                            state_q <= ST_HOLD;
                            if (cand_legal) begin
                                number_q <= cand_value;
                                blank_q  <= 1'b0;
                                valid_q  <= 1'b1;
                            end else if (cand_blank) begin
                                blank_q <= 1'b1;
                                valid_q <= 1'b1;
                            end else begin
                                code_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (seg_q != cand_q) begin
                            cand_q  <= seg_q;
                            cnt_q   <= CW'(1);
                            state_q <= ST_SETTLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FND_RX_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (accept && !cand_legal && !cand_blank && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = '0;
`endif

    assign number   = number_q;
    assign blank    = blank_q;
    assign valid    = valid_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_fnd_rx.sv
// Self-checking bench for fnd_rx (STABLE_CYCLES=4, CNT_W=8).
module tb_fnd_rx;

    localparam int S = 4;
`ifdef FND_RX_ERRCNT_EN
    localparam bit ERR_EN  = 1'b1;
`else
    localparam bit ERR_EN  = 1'b0;
`endif
    localparam int EXP_SAT = ERR_EN ? 255 : 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       sample_en;
    logic       clr_cnt;
    logic [3:0] number;
    logic       blank;
    logic       valid;
    logic       code_err;
    logic [7:0] err_cnt;

    fnd_rx #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .sample_en (sample_en),
        .clr_cnt   (clr_cnt),
        .number    (number),
        .blank     (blank),
        .valid     (valid),
        .code_err  (code_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pv    = 0;
    int pc    = 0;

    logic [6:0] codes [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0D,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: the value the receiver evaluates at a qualified edge is
    // the seg_in sampled at the previous qualified edge; a pattern is accepted
    // when its run of consecutive evaluations reaches exactly S.
    logic [6:0] m_segq, m_prev;
    bit         m_have;
    int         m_run;
    logic [3:0] m_num;
    bit         m_blank, m_valid, m_cerr;
    int         m_err;

    function automatic int lookup(input logic [6:0] v);
        for (int i = 0; i < 16; i++) if (codes[i] == v) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic en, input logic clr, input logic rst);
        logic [6:0] v;
        int idx;
        seg_in = s; sample_en = en; clr_cnt = clr; rst_n = rst;
        @(posedge clk);
        if (!rst) begin
            m_segq = 7'h7F; m_prev = 7'h7F; m_have = 0; m_run = 0;
            m_num = 4'h0; m_blank = 1; m_valid = 0; m_cerr = 0; m_err = 0;
        end else begin
            m_valid = 0; m_cerr = 0;
            if (en) begin
                v = m_segq;
                if (m_have && v == m_prev) m_run++;
                else m_run = 1;
                m_prev = v; m_have = 1;
                if (m_run == S) begin
                    idx = lookup(v);
                    if (idx >= 0) begin
                        m_num = 4'(idx); m_blank = 0; m_valid = 1;
                    end else if (v == 7'h7F) begin
                        m_blank = 1; m_valid = 1;
                    end else begin
                        m_cerr = 1;
                        if (ERR_EN && m_err < 255) m_err++;
                    end
                end
                m_segq = s;
            end
            if (ERR_EN && clr) m_err = 0;
        end
        @(negedge clk);
        check("m_number",   int'(number),   int'(m_num));
        check("m_blank",    int'(blank),    int'(m_blank));
        check("m_valid",    int'(valid),    int'(m_valid));
        check("m_code_err", int'(code_err), int'(m_cerr));
        check("m_err_cnt",  int'(err_cnt),  m_err);
        pv += int'(valid);
        pc += int'(code_err);
    endtask

    task automatic hold(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [6:0] seg;
        int         num;
        bit         blk;
        bit         ill;
    } vec_t;

    vec_t vecs [22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = '{codes[i], i, 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 15, 1'b1, 1'b0};
        vecs[17] = '{7'h7E, 15, 1'b1, 1'b1};
        vecs[18] = '{7'h12,  2, 1'b0, 1'b0};
        vecs[19] = '{7'h55,  2, 1'b0, 1'b1};
        vecs[20] = '{7'h00,  8, 1'b0, 1'b0};
        vecs[21] = '{7'h7D,  8, 1'b0, 1'b1};

        seg_in = 7'h7F; sample_en = 1'b0; clr_cnt = 1'b0; rst_n = 1'b0;
        step(7'h7F, 1'b0, 1'b0, 1'b0);
        step(7'h7F, 1'b1, 1'b0, 1'b0);
        check("rst_number",   int'(number),   0);
        check("rst_blank",    int'(blank),    1);
        check("rst_valid",    int'(valid),    0);
        check("rst_code_err", int'(code_err), 0);
        check("rst_err_cnt",  int'(err_cnt),  0);

        // Plan 1: 7'h12 right after reset
        pv = 0; pc = 0;
        hold(7'h12, 4);
        check("p1_no_early", pv, 0);
        hold(7'h12, 1);
        check("p1_valid",  int'(valid),  1);
        check("p1_number", int'(number), 2);
        check("p1_blank",  int'(blank),  0);
        hold(7'h12, 10);
        check("p1_once", pv, 1);

        // Decode table
        foreach (vecs[k]) begin
            pv = 0; pc = 0;
            hold(vecs[k].seg, 6);
            check("tbl_number",   int'(number), vecs[k].num);
            check("tbl_blank",    int'(blank),  int'(vecs[k].blk));
            check("tbl_valid_n",  pv,           vecs[k].ill ? 0 : 1);
            check("tbl_cerr_n",   pc,           vecs[k].ill ? 1 : 0);
        end

        // Plan 2: abandoned 7'h12, then 7'h06
        hold(7'h30, 6);
        pv = 0;
        hold(7'h12, 2);
        hold(7'h06, 8);
        check("p2_pulses", pv, 1);
        check("p2_number", int'(number), 3);

        // Plan 3: digit, illegal, blank
        hold(7'h4C, 6);
        step(7'h4C, 1'b1, 1'b1, 1'b1);
        check("p3_number4", int'(number), 4);
        pv = 0; pc = 0;
        hold(7'h7E, 6);
        check("p3_cerr",   pc, 1);
        check("p3_nov",    pv, 0);
        check("p3_errcnt", int'(err_cnt), ERR_EN ? 1 : 0);
        check("p3_keep4",  int'(number), 4);
        pv = 0; pc = 0;
        hold(7'h7F, 6);
        check("p3_blank_v", pv, 1);
        check("p3_blank",   int'(blank), 1);
        check("p3_num_kept", int'(number), 4);

        // Plan 4: sample_en gap mid-settle
        hold(7'h20, 6);
        pv = 0;
        hold(7'h24, 3);
        for (int i = 0; i < 10; i++) step(7'h7E, 1'b0, 1'b0, 1'b1);
        check("p4_gap_quiet", pv, 0);
        step(7'h24, 1'b1, 1'b0, 1'b1);
        check("p4_not_yet", int'(valid), 0);
        step(7'h24, 1'b1, 1'b0, 1'b1);
        check("p4_valid",  int'(valid),  1);
        check("p4_number", int'(number), 5);

        // Plan 5: err_cnt saturation and clear priority
        step(7'h24, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 255; i++) hold((i % 2) ? 7'h7D : 7'h7E, 5);
        check("p5_255", int'(err_cnt), EXP_SAT);
        hold(7'h7D, 5);
        check("p5_sat", int'(err_cnt), EXP_SAT);
        hold(7'h7E, 4);
        step(7'h7E, 1'b1, 1'b1, 1'b1);
        check("p5_clr_cerr", int'(code_err), 1);
        check("p5_clr_wins", int'(err_cnt),  0);

        // Plan 6: reset while 7'h38 settles at cnt=3
        hold(7'h12, 6);
        pv = 0;
        hold(7'h38, 4);
        step(7'h38, 1'b1, 1'b0, 1'b0);
        check("p6_no_pulse", pv, 0);
        check("p6_number",   int'(number), 0);
        check("p6_blank",    int'(blank),  1);
        check("p6_errcnt",   int'(err_cnt), 0);
        hold(7'h38, 4);
        check("p6_quiet", pv, 0);
        hold(7'h38, 1);
        check("p6_valid",  int'(valid),  1);
        check("p6_numF",   int'(number), 15);

        // Randomized traffic against the model
        begin
            logic [6:0] cur;
            cur = 7'h7F;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 9) < 2) begin
                    case ($urandom_range(0, 3))
                        0:       cur = 7'($urandom);
                        1:       cur = 7'h7F;
                        default: cur = codes[$urandom_range(0, 15)];
                    endcase
                end
                step(cur, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                     $urandom_range(0, 199) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
